// File: rtl/ara_eoc_pkg.sv
// rtl/ara_eoc_pkg.sv - shared types, register offsets and byte-merge helper for the end-of-computation responder
package ara_eoc_pkg;

    // Word offsets, decoded from addr[4:3]
    localparam logic [1:0] EOC_TOHOST   = 2'd0;
    localparam logic [1:0] EOC_RUNCTRL  = 2'd1;
    localparam logic [1:0] EOC_RUNTIME  = 2'd2;
    localparam logic [1:0] EOC_FROMHOST = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } eoc_state_e;

    // Harness-visible exit word: done flag in bit 0, code above it
    typedef struct packed {
        logic [62:0] code;
        logic        done;
    } exit_t;

    // Replace each byte of old_val whose enable is set with the matching byte of new_val
    function automatic logic [63:0] byte_merge(
        input logic [63:0] old_val,
        input logic [63:0] new_val,
        input logic [7:0]  be
    );
        logic [63:0] res;
        res = old_val;
        for (int i = 0; i < 8; i++) begin
            if (be[i]) begin
                res[i*8 +: 8] = new_val[i*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/eoc_sat_counter.sv
// rtl/eoc_sat_counter.sv - 64-bit up counter with synchronous clear that sticks at all-ones
module eoc_sat_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    output logic [63:0] count
);

    // Clear has priority over counting; the counter never wraps past all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 64'd1;
        end
    end

endmodule

// File: rtl/ara_eoc_ctrl.sv
// rtl/ara_eoc_ctrl.sv - memory-mapped tohost/fromhost responder with runtime counter and watchdog
module ara_eoc_ctrl #(
    parameter int unsigned AddrWidth   = 64,
    parameter logic [63:0] MaxCycles   = 64'd0,
    parameter logic [62:0] TimeoutCode = 63'd1337
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    output logic                 gnt_o,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [63:0]          wdata_i,
    input  logic [7:0]           be_i,
    output logic                 rvalid_o,
    output logic [63:0]          rdata_o,
    output logic [63:0]          exit_o,
    output logic [63:0]          runtime_o,
    output logic                 running_o
);

    import ara_eoc_pkg::*;

    eoc_state_e  state_q, state_d;
    exit_t       exit_q, exit_d;
    logic [63:0] tohost_q;
    logic [63:0] fromhost_q;
    logic        rvalid_q;
    logic [63:0] rdata_q;
    logic [63:0] runtime;
    logic [63:0] wd_count;

    logic [1:0]  offset;
    logic        wr;
    logic        rd;
    logic [63:0] tohost_merged;
    logic [63:0] fromhost_merged;
    logic        tohost_wr;
    logic        fromhost_wr;
    logic        terminate;
    logic        runctrl_wr;
    logic        start;
    logic        stop;
    logic        wd_enabled;
    logic        wd_expire;
    logic        rt_clr;
    logic        rt_en;
    logic [63:0] read_val;
    logic        unused_addr;

    // Only the word offset matters; the rest of the address is don't-care
    assign offset      = addr_i[4:3];
    assign unused_addr = ^{addr_i[AddrWidth-1:5], addr_i[2:0]};

    assign gnt_o = req_i;
    assign wr    = req_i & we_i;
    assign rd    = req_i & ~we_i;

    assign tohost_merged   = byte_merge(tohost_q, wdata_i, be_i);
    assign fromhost_merged = byte_merge(fromhost_q, wdata_i, be_i);

    // Once finished, TOHOST and RUNCTRL writes are acknowledged but dropped
    assign tohost_wr   = wr && (offset == EOC_TOHOST) && (state_q != DONE);
    assign fromhost_wr = wr && (offset == EOC_FROMHOST);
    assign terminate   = tohost_wr && be_i[0] && wdata_i[0];
    assign runctrl_wr  = wr && (offset == EOC_RUNCTRL) && be_i[0] && (state_q != DONE);
    assign start       = runctrl_wr && wdata_i[0];
    assign stop        = runctrl_wr && !wdata_i[0];

    assign wd_enabled = (MaxCycles != 64'd0);
    assign wd_expire  = wd_enabled && (state_q != DONE) && (wd_count == (MaxCycles - 64'd1));

    // Next-state and exit-word selection; a software finish beats a simultaneous watchdog expiry
    always_comb begin
        state_d = state_q;
        exit_d  = exit_q;
        case (state_q)
            IDLE: begin
                if (terminate) begin
                    state_d = DONE;
                    exit_d  = exit_t'(tohost_merged);
                end else if (wd_expire) begin
                    state_d     = DONE;
                    exit_d.code = TimeoutCode;
                    exit_d.done = 1'b1;
                end else if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (terminate) begin
                    state_d = DONE;
                    exit_d  = exit_t'(tohost_merged);
                end else if (wd_expire) begin
                    state_d     = DONE;
                    exit_d.code = TimeoutCode;
                    exit_d.done = 1'b1;
                end else if (stop) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and sticky exit word
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            exit_q  <= '0;
        end else begin
            state_q <= state_d;
            exit_q  <= exit_d;
        end
    end

    // A start clears the runtime; it counts only across edges that keep the FSM in RUN,
    // so the value seen at a stop or finish is the last one counted
    assign rt_clr = start && (state_d == RUN);
    assign rt_en  = (state_q == RUN) && (state_d == RUN);

    eoc_sat_counter u_runtime (
        .clk   (clk_i),
        .rst   (rst_i),
        .clr   (rt_clr),
        .en    (rt_en),
        .count (runtime)
    );

    eoc_sat_counter u_watchdog (
        .clk   (clk_i),
        .rst   (rst_i),
        .clr   (1'b0),
        .en    (wd_enabled && (state_q != DONE)),
        .count (wd_count)
    );

    // Software-visible scratch and tohost registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tohost_q   <= '0;
            fromhost_q <= '0;
        end else begin
            if (tohost_wr) begin
                tohost_q <= tohost_merged;
            end
            if (fromhost_wr) begin
                fromhost_q <= fromhost_merged;
            end
        end
    end

    // Read mux sees register contents before any write landing on the same edge
    always_comb begin
        read_val = '0;
        case (offset)
            EOC_TOHOST:   read_val = tohost_q;
            EOC_RUNCTRL:  read_val = {63'b0, (state_q == RUN)};
            EOC_RUNTIME:  read_val = runtime;
            EOC_FROMHOST: read_val = fromhost_q;
            default:      read_val = '0;
        endcase
    end

    // One-cycle response for every granted access; writes return zero data
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= req_i;
            rdata_q  <= rd ? read_val : 64'd0;
        end
    end

    assign rvalid_o  = rvalid_q;
    assign rdata_o   = rdata_q;
    assign exit_o    = exit_q;
    assign runtime_o = runtime;
    assign running_o = (state_q == RUN);

endmodule

// File: tb/tb_ara_eoc_ctrl.sv
// tb/tb_ara_eoc_ctrl.sv - self-checking bench for ara_eoc_ctrl with a cycle-level reference model
module tb_ara_eoc_ctrl;

    localparam logic [1:0] OFF_TOHOST   = 2'd0;
    localparam logic [1:0] OFF_RUNCTRL  = 2'd1;
    localparam logic [1:0] OFF_RUNTIME  = 2'd2;
    localparam logic [1:0] OFF_FROMHOST = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be;

    logic        gnt, rvalid, running;
    logic [63:0] rdata, exit_w, runtime;
    logic        gnt_wd, rvalid_wd, running_wd;
    logic [63:0] rdata_wd, exit_wd, runtime_wd;

    int     n_checks = 0;
    int     n_errors = 0;
    longint cyc = 0;

    // Reference model state
    logic [63:0] m_tohost, m_fromhost, m_exit;
    bit          m_running, m_done;
    longint      m_start, m_frozen;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ara_eoc_ctrl dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .be_i(be), .rvalid_o(rvalid), .rdata_o(rdata), .exit_o(exit_w),
        .runtime_o(runtime), .running_o(running)
    );

    ara_eoc_ctrl #(.MaxCycles(64'd50)) dut_wd (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt_wd), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .be_i(be), .rvalid_o(rvalid_wd), .rdata_o(rdata_wd), .exit_o(exit_wd),
        .runtime_o(runtime_wd), .running_o(running_wd)
    );

    function automatic logic [63:0] merge(input logic [63:0] old_v, input logic [63:0] new_v, input logic [7:0] b);
        logic [63:0] mask;
        mask = '0;
        for (int i = 0; i < 8; i++) if (b[i]) mask = mask | (64'hFF << (8 * i));
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    function automatic longint model_rt(input longint edge_n);
        return m_running ? (edge_n - m_start) : m_frozen;
    endfunction

    task automatic model_reset();
        m_tohost = '0; m_fromhost = '0; m_exit = '0;
        m_running = 0; m_done = 0; m_start = 0; m_frozen = 0;
    endtask

    task automatic access(input logic w, input logic [1:0] off, input logic [63:0] d, input logic [7:0] b);
        logic [63:0] a;
        a = {$urandom, $urandom};
        a[4:3] = off;
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (exit_w !== 64'd0) begin n_errors++; $display("FAIL reset_exit got=%h want=0", exit_w); end
        n_checks++; if (rvalid !== 1'b0) begin n_errors++; $display("FAIL reset_rvalid got=%b want=0", rvalid); end
        n_checks++; if (runtime !== 64'd0 || running !== 1'b0) begin n_errors++; $display("FAIL reset_runtime got=%h/%b want=0/0", runtime, running); end
        for (int o = 0; o < 4; o++) begin
            access(1'b0, 2'(o), 64'd0, 8'h00);
            n_checks++;
            if (rvalid !== 1'b1 || rdata !== 64'd0)
                begin n_errors++; $display("FAIL reset_read off=%0d got rvalid=%b rdata=%h want 1/0", o, rvalid, rdata); end
        end
        idle(1);
        n_checks++; if (rvalid !== 1'b0) begin n_errors++; $display("FAIL rvalid_drop got=%b want=0", rvalid); end
        n_checks++; if (gnt !== 1'b0) begin n_errors++; $display("FAIL gnt_idle got=%b want=0", gnt); end
    endtask

    task automatic test_runtime();
        longint s, p, first;
        do_reset();
        access(1'b1, OFF_RUNCTRL, 64'd1, 8'hFF);
        s = cyc;
        n_checks++; if (running !== 1'b1 || runtime !== 64'd0) begin n_errors++; $display("FAIL start got=%b/%h want=1/0", running, runtime); end
        idle(100);
        n_checks++; if (runtime !== 64'(cyc - s)) begin n_errors++; $display("FAIL runtime_count got=%0d want=%0d", runtime, cyc - s); end
        access(1'b1, OFF_RUNCTRL, 64'd0, 8'hFF);
        p = cyc;
        access(1'b0, OFF_RUNTIME, 64'd0, 8'h00);
        first = longint'(rdata);
        n_checks++;
        if (rdata !== 64'(p - 1 - s) || first < 99 || first > 101)
            begin n_errors++; $display("FAIL runtime_read got=%0d want=%0d", rdata, p - 1 - s); end
        n_checks++; if (running !== 1'b0) begin n_errors++; $display("FAIL stop got=%b want=0", running); end
        access(1'b1, OFF_RUNTIME, 64'hFFFF, 8'hFF);
        idle(50);
        access(1'b0, OFF_RUNTIME, 64'd0, 8'h00);
        n_checks++; if (rdata !== 64'(first)) begin n_errors++; $display("FAIL runtime_frozen got=%0d want=%0d", rdata, first); end
    endtask

    task automatic test_exit();
        do_reset();
        access(1'b1, OFF_RUNCTRL, 64'd1, 8'hFF);
        idle(3);
        access(1'b1, OFF_TOHOST, 64'h1, 8'hFF);
        n_checks++; if (exit_w !== 64'h1 || running !== 1'b0) begin n_errors++; $display("FAIL exit_set got=%h/%b want=1/0", exit_w, running); end
        access(1'b1, OFF_TOHOST, 64'h7, 8'hFF);
        n_checks++; if (exit_w !== 64'h1 || rvalid !== 1'b1) begin n_errors++; $display("FAIL exit_sticky got=%h/%b want=1/1", exit_w, rvalid); end
        access(1'b1, OFF_RUNCTRL, 64'd1, 8'hFF);
        n_checks++; if (running !== 1'b0) begin n_errors++; $display("FAIL done_runctrl got=%b want=0", running); end
        access(1'b1, OFF_FROMHOST, 64'hDEAD_BEEF_0000_1234, 8'hFF);
        access(1'b0, OFF_FROMHOST, 64'd0, 8'h00);
        n_checks++; if (rdata !== 64'hDEAD_BEEF_0000_1234) begin n_errors++; $display("FAIL done_fromhost got=%h want=deadbeef00001234", rdata); end
    endtask

    task automatic test_partial();
        do_reset();
        access(1'b1, OFF_TOHOST, 64'h6, 8'h01);
        n_checks++; if (exit_w !== 64'd0) begin n_errors++; $display("FAIL partial_even got=%h want=0", exit_w); end
        access(1'b1, OFF_TOHOST, 64'h1, 8'hFE);
        n_checks++; if (exit_w !== 64'd0) begin n_errors++; $display("FAIL partial_upper got=%h want=0", exit_w); end
        access(1'b0, OFF_TOHOST, 64'd0, 8'h00);
        n_checks++; if (rdata !== 64'h6) begin n_errors++; $display("FAIL partial_read got=%h want=6", rdata); end
        access(1'b1, OFF_TOHOST, 64'h7, 8'h01);
        n_checks++; if (exit_w !== 64'h7) begin n_errors++; $display("FAIL partial_exit got=%h want=7", exit_w); end
    endtask

    task automatic test_watchdog();
        do_reset();
        idle(49);
        n_checks++; if (exit_wd !== 64'd0) begin n_errors++; $display("FAIL wd_early got=%h want=0", exit_wd); end
        idle(1);
        n_checks++; if (exit_wd !== {63'd1337, 1'b1}) begin n_errors++; $display("FAIL wd_expire got=%h want=%h", exit_wd, {63'd1337, 1'b1}); end
        n_checks++; if (exit_w !== 64'd0) begin n_errors++; $display("FAIL wd_disabled got=%h want=0", exit_w); end
        idle(5);
        n_checks++; if (exit_wd !== {63'd1337, 1'b1}) begin n_errors++; $display("FAIL wd_sticky got=%h want=%h", exit_wd, {63'd1337, 1'b1}); end
        do_reset();
        idle(49);
        access(1'b1, OFF_TOHOST, 64'h1, 8'h01);
        n_checks++; if (exit_wd !== 64'h1) begin n_errors++; $display("FAIL wd_race got=%h want=1", exit_wd); end
    endtask

    task automatic reset_with_read();
        rst = 1'b1; req = 1'b1; we = 1'b0; addr = 64'h10; be = 8'h00;
        @(posedge clk); #1;
        rst = 1'b0; req = 1'b0;
        model_reset();
    endtask

    task automatic test_reset_mid();
        do_reset();
        access(1'b1, OFF_RUNCTRL, 64'd1, 8'hFF);
        idle(5);
        reset_with_read();
        n_checks++;
        if (rvalid !== 1'b0 || rdata !== 64'd0 || runtime !== 64'd0 || running !== 1'b0 || exit_w !== 64'd0)
            begin n_errors++; $display("FAIL rst_run got rv=%b rd=%h rt=%h run=%b ex=%h want all 0", rvalid, rdata, runtime, running, exit_w); end
        idle(1);
        n_checks++; if (rvalid !== 1'b0) begin n_errors++; $display("FAIL rst_cancel got=%b want=0", rvalid); end
        access(1'b1, OFF_TOHOST, 64'h3, 8'hFF);
        reset_with_read();
        n_checks++;
        if (rvalid !== 1'b0 || exit_w !== 64'd0 || exit_wd !== 64'd0)
            begin n_errors++; $display("FAIL rst_done got rv=%b ex=%h exwd=%h want 0/0/0", rvalid, exit_w, exit_wd); end
        access(1'b0, OFF_TOHOST, 64'd0, 8'h00);
        n_checks++; if (rdata !== 64'd0) begin n_errors++; $display("FAIL rst_tohost got=%h want=0", rdata); end
    endtask

    task automatic test_random();
        logic        w;
        logic [1:0]  off;
        logic [63:0] d, exp_rd;
        logic [7:0]  b;
        longint      e;
        do_reset();
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle(1);
                n_checks++;
                if (rvalid !== 1'b0 || exit_w !== m_exit || running !== m_running || runtime !== 64'(model_rt(cyc)))
                    begin n_errors++; $display("FAIL rand_idle it=%0d got rv=%b ex=%h run=%b rt=%0d want 0/%h/%b/%0d", it, rvalid, exit_w, running, runtime, m_exit, m_running, model_rt(cyc)); end
                continue;
            end
            w   = 1'($urandom);
            off = 2'($urandom);
            d   = {$urandom, $urandom};
            b   = 8'($urandom);
            if (off == OFF_TOHOST) d[0] = ($urandom_range(0, 40) == 0);
            e = cyc + 1;
            exp_rd = 64'd0;
            if (!w) begin
                case (off)
                    OFF_TOHOST:   exp_rd = m_tohost;
                    OFF_RUNCTRL:  exp_rd = {63'd0, m_running};
                    OFF_RUNTIME:  exp_rd = 64'(model_rt(e - 1));
                    default:      exp_rd = m_fromhost;
                endcase
            end else begin
                if (off == OFF_FROMHOST) m_fromhost = merge(m_fromhost, d, b);
                if (off == OFF_TOHOST && !m_done) begin
                    m_tohost = merge(m_tohost, d, b);
                    if (b[0] && d[0]) begin
                        m_done = 1; m_exit = m_tohost;
                        if (m_running) begin m_frozen = e - 1 - m_start; m_running = 0; end
                    end
                end
                if (off == OFF_RUNCTRL && !m_done && b[0]) begin
                    if (d[0]) begin m_running = 1; m_start = e; end
                    else if (m_running) begin m_frozen = e - 1 - m_start; m_running = 0; end
                end
            end
            access(w, off, d, b);
            n_checks++;
            if (rvalid !== 1'b1 || rdata !== exp_rd || exit_w !== m_exit || running !== m_running || runtime !== 64'(model_rt(e)))
                begin n_errors++; $display("FAIL rand_acc it=%0d we=%b off=%0d got rd=%h ex=%h run=%b rt=%0d want rd=%h ex=%h run=%b rt=%0d", it, w, off, rdata, exit_w, running, runtime, exp_rd, m_exit, m_running, model_rt(e)); end
        end
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
        model_reset();
        test_reset();
        test_runtime();
        test_exit();
        test_partial();
        test_watchdog();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
